// File: rtl/weight_ctrl_pkg.sv
// Shared types and defaults for the weight sequencing controller.
package weight_ctrl_pkg;

    localparam int unsigned N_WEIGHTS_DEF = 8001;
    localparam int unsigned IDX_W_DEF     = 13;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        UPD  = 2'd2,
        FIN  = 2'd3
    } state_t;

endpackage

// File: rtl/weight_seq_ctrl_counter.sv
// Modulo-N index counter: counts enabled cycles, wraps to 0 after N-1.
module mod_n_counter #(
    parameter int unsigned N = 8001,
    parameter int unsigned W = 13
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_enable,
    input  logic         i_clear,
    output logic [W-1:0] o_count,
    output logic         o_wrap_c
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    assign o_wrap_c = i_enable && (o_count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_count <= '0;
        end else if (i_clear || o_wrap_c) begin
            o_count <= '0;
        end else if (i_enable) begin
            o_count <= o_count + W'(1);
        end
    end

endmodule

// File: rtl/weight_seq_ctrl.sv
// Sequences forward and update passes over a circular weight store,
// issuing exactly N_WEIGHTS shifts per pass so the rotation stays aligned.
module weight_seq_ctrl
    import weight_ctrl_pkg::*;
#(
    parameter int unsigned N_WEIGHTS = N_WEIGHTS_DEF,
    parameter int unsigned IDX_W     = IDX_W_DEF
) (
    input  logic             Clk,
    input  logic             RST,
    input  logic             start_fwd,
    input  logic             start_upd,
    input  logic [7:0]       w_in,
    input  logic             mac_ready,
    input  logic [7:0]       delta_in,
    input  logic             delta_valid,
    output logic             ComputeH,
    output logic             Get,
    output logic             Update,
    output logic [7:0]       delta_w,
    output logic [7:0]       w_data,
    output logic             w_valid,
    output logic [IDX_W-1:0] w_idx,
    output logic             busy,
    output logic             done
);

    state_t r_state;
    state_t w_next_state;
    logic   w_cnt_en;
    logic   w_cnt_clr;
    logic   w_wrap;

    // A transfer is a consumer accept in FWD or a qualified delta in UPD.
    assign w_cnt_en  = ((r_state == FWD) && mac_ready) ||
                       ((r_state == UPD) && delta_valid);
    assign w_cnt_clr = (r_state == IDLE);

    mod_n_counter #(
        .N (N_WEIGHTS),
        .W (IDX_W)
    ) u_idx (
        .clk      (Clk),
        .rst      (RST),
        .i_enable (w_cnt_en),
        .i_clear  (w_cnt_clr),
        .o_count  (w_idx),
        .o_wrap_c (w_wrap)
    );

    always_ff @(posedge Clk or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        ComputeH     = 1'b0;
        Get          = 1'b0;
        Update       = 1'b0;
        delta_w      = 8'h00;
        w_data       = 8'h00;
        w_valid      = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;

        case (r_state)
            IDLE: begin
                // Forward wins a simultaneous request; the update request is dropped.
                if (start_fwd) begin
                    w_next_state = FWD;
                end else if (start_upd) begin
                    w_next_state = UPD;
                end
            end
            FWD: begin
                busy     = 1'b1;
                w_valid  = 1'b1;
                w_data   = w_in;
                ComputeH = mac_ready;
                Get      = mac_ready;
                if (w_wrap) begin
                    w_next_state = FIN;
                end
            end
            UPD: begin
                busy    = 1'b1;
                Update  = delta_valid;
                delta_w = delta_valid ? delta_in : 8'h00;
                if (w_wrap) begin
                    w_next_state = FIN;
                end
            end
            FIN: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_weight_seq_ctrl.sv
// Bench for weight_seq_ctrl: a small (8-entry) and a default-size instance,
// each driving a behavioural circular store.
module tb_weight_seq_ctrl;

    localparam int NS = 8;
    localparam int NB = 8001;

    logic Clk = 1'b0;
    logic RST;
    logic mac_ready, delta_valid;
    logic [7:0] delta_in;

    logic start_fwd_s, start_upd_s, start_fwd_b, start_upd_b;
    logic [7:0] w_in_s, w_in_b;
    logic ComputeH_s, Get_s, Update_s, w_valid_s, busy_s, done_s;
    logic ComputeH_b, Get_b, Update_b, w_valid_b, busy_b, done_b;
    logic [7:0] delta_w_s, w_data_s, delta_w_b, w_data_b;
    logic [2:0]  w_idx_s;
    logic [12:0] w_idx_b;

    logic [7:0] st_s [NS];
    logic [7:0] st_b [NB];
    logic [7:0] snap_b [NB];
    int hd_s, hd_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clk = ~Clk;

    weight_seq_ctrl #(.N_WEIGHTS(NS), .IDX_W(3)) u_s (
        .Clk(Clk), .RST(RST), .start_fwd(start_fwd_s), .start_upd(start_upd_s),
        .w_in(w_in_s), .mac_ready(mac_ready), .delta_in(delta_in), .delta_valid(delta_valid),
        .ComputeH(ComputeH_s), .Get(Get_s), .Update(Update_s), .delta_w(delta_w_s),
        .w_data(w_data_s), .w_valid(w_valid_s), .w_idx(w_idx_s), .busy(busy_s), .done(done_s)
    );

    weight_seq_ctrl u_b (
        .Clk(Clk), .RST(RST), .start_fwd(start_fwd_b), .start_upd(start_upd_b),
        .w_in(w_in_b), .mac_ready(mac_ready), .delta_in(delta_in), .delta_valid(delta_valid),
        .ComputeH(ComputeH_b), .Get(Get_b), .Update(Update_b), .delta_w(delta_w_b),
        .w_data(w_data_b), .w_valid(w_valid_b), .w_idx(w_idx_b), .busy(busy_b), .done(done_b)
    );

    function automatic logic [7:0] sat8(input logic [7:0] a, input logic [7:0] b);
        int s;
        s = int'($signed(a)) + int'($signed(b));
        if (s > 127) s = 127;
        else if (s < -128) s = -128;
        return 8'(s);
    endfunction

    // Behavioural circular stores: the head rotates on every Get or Update.
    assign w_in_s = st_s[hd_s];
    assign w_in_b = st_b[hd_b];

    always @(posedge Clk or posedge RST) begin
        if (RST) begin
            hd_s <= 0;
            for (int i = 0; i < NS; i++) st_s[i] <= 8'($urandom);
        end else if (Get_s) begin
            hd_s <= (hd_s + 1) % NS;
        end else if (Update_s) begin
            st_s[hd_s] <= sat8(st_s[hd_s], delta_w_s);
            hd_s <= (hd_s + 1) % NS;
        end
    end

    always @(posedge Clk or posedge RST) begin
        if (RST) begin
            hd_b <= 0;
            for (int i = 0; i < NB; i++) st_b[i] <= 8'($urandom);
        end else if (Get_b) begin
            hd_b <= (hd_b + 1) % NB;
        end else if (Update_b) begin
            st_b[hd_b] <= sat8(st_b[hd_b], delta_w_b);
            hd_b <= (hd_b + 1) % NB;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet_s(input string tag);
        chk({tag, "_computeh"}, ComputeH_s, 0);
        chk({tag, "_get"},      Get_s, 0);
        chk({tag, "_update"},   Update_s, 0);
        chk({tag, "_wvalid"},   w_valid_s, 0);
        chk({tag, "_deltaw"},   delta_w_s, 0);
    endtask

    // One pass on the small instance. pat: 0 always accept, 1 alternate 1/0, 2 random.
    // poke pulses the other start request mid-pass, which must be ignored.
    task automatic run_pass_s(input bit sf, input bit su, input int pat, input bit poke);
        logic [7:0] snap [NS];
        logic [7:0] dl [NS];
        logic [7:0] d;
        int h0, k, cyc;
        bit go, fwd;
        fwd = sf;
        h0  = hd_s;
        for (int i = 0; i < NS; i++) begin
            snap[i] = st_s[(h0 + i) % NS];
            dl[i]   = 8'h00;
        end
        @(negedge Clk);
        start_fwd_s = sf; start_upd_s = su; mac_ready = 1'b0; delta_valid = 1'b0;
        #1;
        chk("idle_busy", busy_s, 0);
        k = 0; cyc = 0;
        while (k < NS && cyc < 100) begin
            @(negedge Clk);
            cyc++;
            start_fwd_s = poke && (cyc == 3) && !fwd;
            start_upd_s = poke && (cyc == 3) && fwd;
            if (pat == 0)      go = 1'b1;
            else if (pat == 1) go = (cyc % 2) == 1;
            else               go = 1'($urandom_range(0, 1));
            d = (pat == 1) ? 8'hFF : 8'($urandom);
            delta_in = d;
            if (fwd) begin
                mac_ready = go; delta_valid = 1'($urandom_range(0, 1));
            end else begin
                delta_valid = go; mac_ready = 1'($urandom_range(0, 1));
            end
            #1;
            chk("pass_idx",  w_idx_s, k);
            chk("pass_busy", busy_s, 1);
            chk("pass_done", done_s, 0);
            if (fwd) begin
                chk("fwd_wvalid",   w_valid_s, 1);
                chk("fwd_wdata",    w_data_s, snap[k]);
                chk("fwd_computeh", ComputeH_s, go);
                chk("fwd_get",      Get_s, go);
                chk("fwd_update",   Update_s, 0);
                chk("fwd_deltaw",   delta_w_s, 0);
            end else begin
                chk("upd_update",   Update_s, go);
                chk("upd_deltaw",   delta_w_s, go ? d : 8'h00);
                chk("upd_computeh", ComputeH_s, 0);
                chk("upd_get",      Get_s, 0);
                chk("upd_wvalid",   w_valid_s, 0);
            end
            if (go) begin
                dl[k] = d;
                k++;
            end
        end
        chk("pass_len", k, NS);
        @(negedge Clk);
        start_fwd_s = 1'b0; start_upd_s = 1'b0; mac_ready = 1'b1; delta_valid = 1'b1;
        #1;
        chk("fin_done", done_s, 1);
        chk("fin_busy", busy_s, 1);
        chk("fin_idx",  w_idx_s, 0);
        chk_quiet_s("fin");
        @(negedge Clk);
        #1;
        chk("post_done", done_s, 0);
        chk("post_busy", busy_s, 0);
        chk_quiet_s("post");
        chk("head_aligned", hd_s, h0);
        if (!fwd) begin
            for (int i = 0; i < NS; i++)
                chk("store_updated", st_s[(h0 + i) % NS], sat8(snap[i], dl[i]));
        end
    endtask

    initial begin
        int cyc, bad, h0;
        bit saw;
        RST = 1'b1;
        start_fwd_s = 1'b0; start_upd_s = 1'b0; start_fwd_b = 1'b0; start_upd_b = 1'b0;
        mac_ready = 1'b1; delta_valid = 1'b1; delta_in = 8'h5A;
        repeat (3) @(negedge Clk);
        #1;
        chk("rst_idx_s", w_idx_s, 0);
        chk("rst_busy_s", busy_s, 0);
        chk("rst_done_s", done_s, 0);
        chk_quiet_s("rst");
        chk("rst_idx_b", w_idx_b, 0);
        chk("rst_busy_b", busy_b, 0);
        chk("rst_done_b", done_b, 0);
        @(negedge Clk);
        RST = 1'b0;

        run_pass_s(1'b1, 1'b0, 0, 1'b0);
        run_pass_s(1'b0, 1'b1, 1, 1'b0);
        run_pass_s(1'b1, 1'b1, 0, 1'b0);
        repeat (3) begin
            @(negedge Clk);
            #1;
            chk("no_upd_after_both", busy_s, 0);
        end
        run_pass_s(1'b1, 1'b0, 2, 1'b1);
        run_pass_s(1'b0, 1'b1, 2, 1'b1);
        repeat (3) begin
            run_pass_s(1'b1, 1'b0, 2, 1'b0);
            run_pass_s(1'b0, 1'b1, 2, 1'b0);
        end

        // Abort a forward pass at index 3 with an asynchronous reset.
        @(negedge Clk);
        start_fwd_s = 1'b1; mac_ready = 1'b1; delta_valid = 1'b0;
        repeat (4) begin
            @(negedge Clk);
            start_fwd_s = 1'b0;
        end
        #1;
        chk("abort_pre_idx", w_idx_s, 3);
        #2;
        RST = 1'b1;
        #1;
        chk("abort_idx", w_idx_s, 0);
        chk("abort_busy", busy_s, 0);
        chk("abort_done", done_s, 0);
        chk_quiet_s("abort");
        repeat (2) @(negedge Clk);
        RST = 1'b0;
        saw = 1'b0;
        repeat (12) begin
            @(negedge Clk);
            #1;
            if (done_s || busy_s) saw = 1'b1;
        end
        chk("abort_no_done", saw, 0);

        // Full-size forward pass on the default instance.
        h0 = hd_b;
        for (int i = 0; i < NB; i++) snap_b[i] = st_b[(h0 + i) % NB];
        @(negedge Clk);
        start_fwd_b = 1'b1; mac_ready = 1'b1; delta_valid = 1'b0;
        bad = 0;
        for (cyc = 1; cyc <= 9000; cyc++) begin
            @(negedge Clk);
            start_fwd_b = 1'b0;
            #1;
            if (done_b) break;
            if (w_data_b !== snap_b[cyc - 1] || w_idx_b !== 13'(cyc - 1) || Get_b !== 1'b1)
                bad++;
        end
        chk("big_latency", cyc, NB + 1);
        chk("big_stream", bad, 0);
        @(negedge Clk);
        #1;
        chk("big_post_busy", busy_b, 0);
        chk("big_head_aligned", hd_b, h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/weight_seq_ctrl.md
WEIGHT_SEQ_CTRL -- requirements
Module: weight_seq_ctrl

Interface
REQ-001 Parameter N_WEIGHTS, default 8001, SHALL give the number of 8-bit entries in the circular weight store.
REQ-002 Parameter IDX_W, default 13, SHALL give the index width; IDX_W SHALL satisfy 2**IDX_W >= N_WEIGHTS.
REQ-003 Clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 RST  in  1  SHALL be the asynchronous, active-high reset.
REQ-005 start_fwd  in  1  SHALL request a forward pass, reading every weight once.
REQ-006 start_upd  in  1  SHALL request an update pass, adding one delta to every weight.
REQ-007 w_in  in  8  SHALL be the current head weight from the store.
REQ-008 mac_ready  in  1  SHALL indicate that the consumer accepts w_data this cycle.
REQ-009 delta_in  in  8  SHALL be the signed delta for the current head weight.
REQ-010 delta_valid  in  1  SHALL qualify delta_in.
REQ-011 ComputeH, Get, Update  out  1 each  SHALL be the store shift controls.
REQ-012 delta_w  out  8  SHALL be the delta sent to the store.
REQ-013 w_data  out  8 and w_valid  out  1  SHALL carry the weight stream to the consumer.
REQ-014 w_idx  out  IDX_W  SHALL be the index of the current head entry within the pass.
REQ-015 busy  out  1 and done  out  1  SHALL report pass status.

Function
REQ-016 The FSM SHALL have the states IDLE, FWD, UPD and FIN.
REQ-017 In IDLE: start_fwd SHALL go to FWD; otherwise start_upd SHALL go to UPD. If both are high, FWD SHALL win and start_upd SHALL be dropped.
REQ-018 start_fwd and start_upd SHALL be ignored, not queued, in every state other than IDLE.
REQ-019 Entering FWD or UPD SHALL clear w_idx to 0.
REQ-020 busy SHALL be high in FWD, UPD and FIN.
REQ-021 In FWD, each cycle: w_valid=1, w_data=w_in (combinational), and ComputeH=Get=mac_ready.
REQ-022 In FWD, w_idx SHALL increment only on cycles where mac_ready=1; mac_ready=0 SHALL stall with no store shift.
REQ-023 In UPD, each cycle: Update=delta_valid, delta_w=delta_in when delta_valid=1, else 0.
REQ-024 In UPD, w_idx SHALL increment only on cycles where delta_valid=1.
REQ-025 ComputeH/Get and Update SHALL never be high in the same cycle; all three SHALL be 0 outside FWD/UPD.
REQ-026 The transfer accepted at w_idx=N_WEIGHTS-1 SHALL move the FSM to FIN and wrap w_idx to 0.
REQ-027 Each pass SHALL therefore perform exactly N_WEIGHTS shifts, leaving the store rotation aligned.
REQ-028 FIN SHALL last one cycle, with done=1, then return to IDLE; done SHALL be 0 in all other states.
REQ-029 Minimum pass latency from start to done SHALL be N_WEIGHTS+1 cycles.
REQ-030 Saturation of weight+delta SHALL remain in the store; this block SHALL pass delta_in unmodified.

Reset
REQ-031 RST=1 SHALL immediately force state=IDLE and w_idx=0.
REQ-032 During RST, all control outputs, w_valid, busy and done SHALL be 0, and delta_w SHALL be 0.
REQ-033 RST asserted mid-pass SHALL abort the pass with no done pulse; the store is reset by the same RST.

Structure
REQ-034 A shared package weight_ctrl_pkg SHALL hold the state enum (IDLE, FWD, UPD, FIN), the default N_WEIGHTS and the default IDX_W.
REQ-035 The index counter SHALL be a sub-module named mod_n_counter, with ports: enable, clear, count, wrap pulse.
REQ-036 The FSM and output decode SHALL reside in weight_seq_ctrl.

Verification
REQ-037 The bench SHALL cover these directed scenarios (N_WEIGHTS=8 for speed unless stated):
- Reset, then start_fwd with mac_ready=1 -> 8 cycles of ComputeH=Get=1, w_idx 0..7, then done=1 on cycle 9; busy=0 on cycle 10.
- UPD with delta_in=8'hFF and delta_valid toggling 1,0,1,0... -> Update high on exactly 8 cycles, delta_w=0 on stall cycles, single done pulse.
- start_fwd and start_upd in the same cycle -> FWD pass; no UPD follows.
- start_upd pulsed mid-FWD -> ignored; FWD completes; FSM returns to IDLE.
- RST asserted at w_idx=3 of a FWD pass -> outputs 0 asynchronously, no done, w_idx=0.
- Default N_WEIGHTS=8001 FWD pass with mac_ready=1 -> done exactly 8002 cycles after start; stored weights return to their original order.
